mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single banked-memory port between the I-cache and D-cache adapters.
//  Grants the command channel per request: one-beat read commands, four-beat write bursts.
//  Tracks outstanding reads in issue order and steers returned beats (rdata/raddr/rvalid) to their owner.
//  Sits between the two cache adapters and the top-level memory port.
// PARAMETERS
//  OUTSTANDING_DEPTH  4   max read commands in flight (power of 2, >=2)
//  BURST_BEATS        4   64-bit beats per 256-bit line (fixed by line size)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  i_addr/d_addr  in   32  requester line address
//  i_read/d_read  in   1   read command request
//  i_write/d_write in  1   write beat request
//  i_wdata/d_wdata in  64  write beat data
//  i_ready/d_ready out 1   command/beat accepted this cycle
//  i_rdata/d_rdata out 64  returned read beat (fanned out from bmem_rdata)
//  i_raddr/d_raddr out 32  returned beat address (fanned out from bmem_raddr)
//  i_rvalid/d_rvalid out 1 beat valid for this requester
//  bmem_addr      out  32  granted address
//  bmem_read      out  1   read command
//  bmem_write     out  1   write beat
//  bmem_wdata     out  64  write beat data
//  bmem_ready     in   1   memory accepts command/beat
//  bmem_rdata     in   64  read beat data
//  bmem_raddr     in   32  read beat address
//  bmem_rvalid    in   1   read beat valid
// BEHAVIOUR
//  Reset: all outputs 0, FSM=ARB_IDLE, rr_ptr=D, outstanding FIFO empty, beat counters 0.
//  FSM ARB_IDLE: winner = requester asserting read|write; both -> round robin, rr_ptr names the preferred one.
//   Winner's read|write and addr/wdata drive bmem_* combinationally in the same cycle; winner's ready = bmem_ready.
//   Loser's ready=0. rr_ptr flips to the loser only on an accepted command (ready=1).
//   Accepted read: push owner id into FIFO, stay ARB_IDLE (one command = whole burst).
//   Read blocked (FIFO full, count==DEPTH): that requester is ineligible; a pending write from the other still wins.
//   No bypass: full FIFO blocks issue even if a pop occurs the same cycle.
//   Accepted write beat 0: latch owner+addr, wbeat=1, go ARB_WBURST.
//  ARB_WBURST: owner locked; bmem_addr=latched addr; owner's ready=bmem_ready; other ready=0.
//   Each accepted beat increments wbeat; beat BURST_BEATS-1 accepted -> ARB_IDLE, rr_ptr flips to the non-owner.
//   Owner dropping write mid-burst: bmem_write=0, hold state (adapters never abort writes).
//  Return path: independent of FSM. bmem_rvalid with FIFO non-empty -> rvalid to FIFO-head owner only, same cycle.
//   rbeat counts 0..3; pop FIFO on the 4th beat, rbeat wraps to 0. Beats need not be consecutive.
//   Beats route regardless of requester state (a mispredict-abandoned burst still drains).
//   rvalid with empty FIFO: dropped, both rvalid=0; simulation assertion fires.
//  Simultaneous push and pop: count unchanged, both pointers advance.
//  Reset mid-burst: everything cleared. Memory is reset on the same rst, so no stale beats arrive.
//  Latency: 0 cycles added on command and return paths (pure muxing plus state).
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds outputs perf_i_grants, perf_d_grants, perf_conflicts (32b each, saturating).
//   Grants count accepted reads plus accepted write-burst first beats.
//   perf_conflicts counts cycles in ARB_IDLE where both requesters request.
//   All counters reset to 0.
//  MEM_ARB_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum {REQ_I, REQ_D} req_id_t;
//   typedef enum {ARB_IDLE, ARB_WBURST} arb_state_t; localparam BURST_BEATS=4.
//  Sub-module mem_arb_order_fifo: sync FIFO of req_id_t, DEPTH param; push/pop/full/empty/head.
// TESTING
//  1 I read 0x1000 alone, bmem_ready=1 -> bmem_read=1 addr 0x1000 same cycle; 4 rvalid beats raddr 0x1000 -> i_rvalid x4, d_rvalid=0.
//  2 I read and D read same cycle after reset -> D granted first (rr_ptr=D), I next cycle; returns route D then I.
//  3 D write burst 0x2000, I read asserted throughout -> 4 D beats uninterrupted, then I read granted the cycle after beat 3.
//  4 Reads issued until FIFO full, bmem_rvalid held 0 -> 5th read: ready=0, no bmem_read; 4th return beat frees a slot, issue next cycle.
//  5 bmem_ready toggling 1,0,1,0 during D write -> wbeat advances only on ready=1, bmem_addr stable, exactly 4 beats.
//  6 rst asserted mid-write-burst (wbeat=2) -> next cycle FSM=ARB_IDLE, all outputs 0, FIFO empty; new I read granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the banked-memory port
//               arbiter (requester ids, arbiter states, burst length).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Requester identity; also the entry type of the outstanding-read FIFO
    typedef enum logic [0:0] {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // Command-channel arbiter states
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_WBURST = 1'b1
    } arb_state_t;

    // 64-bit beats per 256-bit line
    localparam int BURST_BEATS = 4;

    // The requester that is not r
    function automatic req_id_t other_req(input req_id_t r);
        return (r == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_order_fifo
// Description : Synchronous FIFO of requester ids recording the issue order
//               of read commands, so returned beats can be steered to their
//               owner. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_order_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_t head
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    req_id_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    // Pushes into a full FIFO and pops from an empty one are ignored
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= REQ_I;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_id;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the banked-memory port between the I-cache and
//               D-cache adapters. Round-robin grant of one-beat read commands
//               and locked four-beat write bursts; read returns are steered
//               to their owner in issue order. Zero added latency.
//               Optional: MEM_ARB_PERF_EN adds saturating grant/conflict
//               counters (perf_i_grants, perf_d_grants, perf_conflicts).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    // I-cache adapter
    input  logic [31:0] i_addr,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [63:0] i_wdata,
    output logic        i_ready,
    output logic [63:0] i_rdata,
    output logic [31:0] i_raddr,
    output logic        i_rvalid,
    // D-cache adapter
    input  logic [31:0] d_addr,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic [31:0] d_raddr,
    output logic        d_rvalid,
    // Memory port
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [63:0] bmem_wdata,
    input  logic        bmem_ready,
    input  logic [63:0] bmem_rdata,
    input  logic [31:0] bmem_raddr,
    input  logic        bmem_rvalid
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts
`endif
);

    localparam int                  c_BEAT_W     = $clog2(BURST_BEATS);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT  = c_BEAT_W'(BURST_BEATS - 1);
    localparam logic [0:0]          c_ARB_IDLE   = 1'(ARB_IDLE);
    localparam logic [0:0]          c_ARB_WBURST = 1'(ARB_WBURST);

    logic [0:0]          r_state;
    req_id_t             r_rr_ptr;
    req_id_t             r_owner;
    logic [31:0]         r_wr_addr;
    logic [c_BEAT_W-1:0] r_wbeat;
    logic [c_BEAT_W-1:0] r_rbeat;

    logic    w_fifo_full;
    logic    w_fifo_empty;
    req_id_t w_fifo_head;
    logic    w_pop;
    logic    w_ret_valid;

    logic    w_i_cmd_rd, w_i_cmd_wr, w_i_elig;
    logic    w_d_cmd_rd, w_d_cmd_wr, w_d_elig;
    req_id_t w_winner;
    logic    w_have_winner;
    logic    w_accept_rd;
    logic    w_accept_wr;
    logic    w_beat_acc;

    // A requester with a write is always eligible; a read only while the
    // order FIFO has room (a same-cycle pop does not make room)
    assign w_i_cmd_wr = i_write;
    assign w_i_cmd_rd = i_read & ~i_write & ~w_fifo_full;
    assign w_i_elig   = w_i_cmd_wr | w_i_cmd_rd;
    assign w_d_cmd_wr = d_write;
    assign w_d_cmd_rd = d_read & ~d_write & ~w_fifo_full;
    assign w_d_elig   = w_d_cmd_wr | w_d_cmd_rd;
    assign w_have_winner = w_i_elig | w_d_elig;

    // Idle-state winner selection: rr_ptr breaks ties
    always_comb begin
        w_winner = REQ_I;
        if (w_i_elig && w_d_elig) begin
            w_winner = r_rr_ptr;
        end else if (w_d_elig) begin
            w_winner = REQ_D;
        end
    end

    // Command-channel muxing towards the memory port and ready back-pressure
    always_comb begin
        bmem_addr   = '0;
        bmem_wdata  = '0;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        w_accept_rd = 1'b0;
        w_accept_wr = 1'b0;
        w_beat_acc  = 1'b0;
        if (r_state == c_ARB_IDLE) begin
            if (w_have_winner) begin
                if (w_winner == REQ_I) begin
                    bmem_addr  = i_addr;
                    bmem_wdata = i_wdata;
                    bmem_read  = w_i_cmd_rd;
                    bmem_write = w_i_cmd_wr;
                    i_ready    = bmem_ready;
                end else begin
                    bmem_addr  = d_addr;
                    bmem_wdata = d_wdata;
                    bmem_read  = w_d_cmd_rd;
                    bmem_write = w_d_cmd_wr;
                    d_ready    = bmem_ready;
                end
                w_accept_rd = bmem_ready & bmem_read;
                w_accept_wr = bmem_ready & bmem_write;
            end
        end else begin
            // Burst in progress: owner locked, address held from beat 0
            bmem_addr = r_wr_addr;
            if (r_owner == REQ_I) begin
                bmem_wdata = i_wdata;
                bmem_write = i_write;
                i_ready    = bmem_ready;
            end else begin
                bmem_wdata = d_wdata;
                bmem_write = d_write;
                d_ready    = bmem_ready;
            end
            w_beat_acc = bmem_ready & bmem_write;
        end
    end

    // Arbiter FSM: round-robin pointer, burst ownership and beat counting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ARB_IDLE;
            r_rr_ptr  <= REQ_D;
            r_owner   <= REQ_I;
            r_wr_addr <= '0;
            r_wbeat   <= '0;
        end else begin
            case (r_state)
                c_ARB_IDLE: begin
                    if (w_accept_rd || w_accept_wr) begin
                        r_rr_ptr <= other_req(w_winner);
                    end
                    if (w_accept_wr) begin
                        r_owner   <= w_winner;
                        r_wr_addr <= bmem_addr;
                        r_wbeat   <= c_BEAT_W'(1);
                        r_state   <= c_ARB_WBURST;
                    end
                end
                c_ARB_WBURST: begin
                    if (w_beat_acc) begin
                        if (r_wbeat == c_LAST_BEAT) begin
                            r_wbeat  <= '0;
                            r_state  <= c_ARB_IDLE;
                            r_rr_ptr <= other_req(r_owner);
                        end else begin
                            r_wbeat <= r_wbeat + c_BEAT_W'(1);
                        end
                    end
                end
                default: r_state <= c_ARB_IDLE;
            endcase
        end
    end

    // Outstanding-read order tracking
    mem_arb_order_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_accept_rd),
        .push_id (w_winner),
        .pop     (w_pop),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .head    (w_fifo_head)
    );

    // Return path: beats go to the FIFO-head owner; beats with nothing
    // outstanding are dropped
    assign w_ret_valid = bmem_rvalid & ~w_fifo_empty;
    assign w_pop       = w_ret_valid & (r_rbeat == c_LAST_BEAT);
    assign i_rvalid    = w_ret_valid & (w_fifo_head == REQ_I);
    assign d_rvalid    = w_ret_valid & (w_fifo_head == REQ_D);
    assign i_rdata     = bmem_rdata;
    assign d_rdata     = bmem_rdata;
    assign i_raddr     = bmem_raddr;
    assign d_raddr     = bmem_raddr;

    // Return beat counter; wraps to 0 on the last beat of a line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rbeat <= '0;
        end else if (w_ret_valid) begin
            r_rbeat <= r_rbeat + c_BEAT_W'(1);
        end
    end

    a_no_orphan_beat: assert property (@(posedge clk) disable iff (rst)
        !(bmem_rvalid && w_fifo_empty));

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_i_grants;
    logic [31:0] r_perf_d_grants;
    logic [31:0] r_perf_conflicts;
    logic        w_grant;
    logic        w_conflict;

    assign w_grant    = w_accept_rd | w_accept_wr;
    assign w_conflict = (r_state == c_ARB_IDLE) & (i_read | i_write) & (d_read | d_write);

    // Saturating grant and conflict counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_i_grants  <= '0;
            r_perf_d_grants  <= '0;
            r_perf_conflicts <= '0;
        end else begin
            if (w_grant && (w_winner == REQ_I) && (r_perf_i_grants != '1)) begin
                r_perf_i_grants <= r_perf_i_grants + 32'd1;
            end
            if (w_grant && (w_winner == REQ_D) && (r_perf_d_grants != '1)) begin
                r_perf_d_grants <= r_perf_d_grants + 32'd1;
            end
            if (w_conflict && (r_perf_conflicts != '1)) begin
                r_perf_conflicts <= r_perf_conflicts + 32'd1;
            end
        end
    end

    assign perf_i_grants  = r_perf_i_grants;
    assign perf_d_grants  = r_perf_d_grants;
    assign perf_conflicts = r_perf_conflicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, table-driven bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [31:0] c_IA  = 32'h0000_1000;
    localparam logic [31:0] c_DA  = 32'h0000_2000;
    localparam logic [63:0] c_IWD = 64'hAAAA_0000_0000_1111;
    localparam logic [63:0] c_DWD = 64'hBBBB_0000_0000_2222;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, bmem_addr, bmem_raddr, i_raddr, d_raddr;
    logic        i_read, i_write, d_read, d_write;
    logic [63:0] i_wdata, d_wdata, bmem_wdata, bmem_rdata, i_rdata, d_rdata;
    logic        i_ready, d_ready, i_rvalid, d_rvalid;
    logic        bmem_read, bmem_write, bmem_ready, bmem_rvalid;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.OUTSTANDING_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_addr     (i_addr),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_wdata    (i_wdata),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .i_raddr    (i_raddr),
        .i_rvalid   (i_rvalid),
        .d_addr     (d_addr),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .d_raddr    (d_raddr),
        .d_rvalid   (d_rvalid),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata),
        .bmem_raddr (bmem_raddr),
        .bmem_rvalid(bmem_rvalid)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_i_grants (perf_i_grants),
        .perf_d_grants (perf_d_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    typedef struct {
        logic        ir, iw, dr, dw, rdy;
        logic        e_rd, e_wr;
        logic [31:0] e_addr;
        logic [63:0] e_wdata;
        logic        e_ir, e_dr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0;
        i_addr = c_IA; d_addr = c_DA; i_wdata = c_IWD; d_wdata = c_DWD;
        bmem_ready = 0; bmem_rvalid = 0; bmem_rdata = '0; bmem_raddr = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bmem_read"},  64'(bmem_read),  64'd0);
        chk({tag, "_bmem_write"}, 64'(bmem_write), 64'd0);
        chk({tag, "_bmem_addr"},  64'(bmem_addr),  64'd0);
        chk({tag, "_bmem_wdata"}, bmem_wdata,      64'd0);
        chk({tag, "_i_ready"},    64'(i_ready),    64'd0);
        chk({tag, "_d_ready"},    64'(d_ready),    64'd0);
        chk({tag, "_i_rvalid"},   64'(i_rvalid),   64'd0);
        chk({tag, "_d_rvalid"},   64'(d_rvalid),   64'd0);
    endtask

    // Watchdog: the bench never waits on the DUT, but guard against runaway
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        //            ir iw dr dw rdy  rd wr addr  wdata  ir dr
        vecs[0] = '{1, 0, 0, 0, 1,   1, 0, c_IA, c_IWD, 1, 0};
        vecs[1] = '{0, 0, 1, 0, 1,   1, 0, c_DA, c_DWD, 0, 1};
        vecs[2] = '{1, 0, 1, 0, 1,   1, 0, c_DA, c_DWD, 0, 1};
        vecs[3] = '{1, 0, 1, 0, 0,   1, 0, c_DA, c_DWD, 0, 0};
        vecs[4] = '{0, 1, 1, 0, 1,   1, 0, c_DA, c_DWD, 0, 1};
        vecs[5] = '{0, 1, 0, 0, 1,   0, 1, c_IA, c_IWD, 1, 0};
        vecs[6] = '{0, 0, 0, 0, 1,   0, 0, '0,   '0,    0, 0};
        vecs[7] = '{1, 0, 0, 1, 1,   0, 1, c_DA, c_DWD, 0, 1};

        // Reset state
        do_reset();
        settle();
        chk_all_zero("reset");

        // Single-cycle arbitration vectors from a fresh reset (rr_ptr = D)
        for (int v = 0; v < 8; v++) begin
            do_reset();
            i_read = vecs[v].ir; i_write = vecs[v].iw;
            d_read = vecs[v].dr; d_write = vecs[v].dw;
            bmem_ready = vecs[v].rdy;
            settle();
            chk($sformatf("vec%0d_read", v),  64'(bmem_read),  64'(vecs[v].e_rd));
            chk($sformatf("vec%0d_write", v), 64'(bmem_write), 64'(vecs[v].e_wr));
            chk($sformatf("vec%0d_addr", v),  64'(bmem_addr),  64'(vecs[v].e_addr));
            chk($sformatf("vec%0d_wdata", v), bmem_wdata,      vecs[v].e_wdata);
            chk($sformatf("vec%0d_iready", v), 64'(i_ready),   64'(vecs[v].e_ir));
            chk($sformatf("vec%0d_dready", v), 64'(d_ready),   64'(vecs[v].e_dr));
        end

        // 1: lone I read, four returns to I
        do_reset();
        i_read = 1; bmem_ready = 1;
        settle();
        chk("t1_read", 64'(bmem_read), 64'd1);
        chk("t1_addr", 64'(bmem_addr), 64'(c_IA));
        tick();
        i_read = 0;
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1; bmem_raddr = c_IA; bmem_rdata = 64'h100 + 64'(b);
            settle();
            chk($sformatf("t1_b%0d_irv", b), 64'(i_rvalid), 64'd1);
            chk($sformatf("t1_b%0d_drv", b), 64'(d_rvalid), 64'd0);
            chk($sformatf("t1_b%0d_rdata", b), i_rdata, 64'h100 + 64'(b));
            chk($sformatf("t1_b%0d_raddr", b), 64'(i_raddr), 64'(c_IA));
            tick();
        end
        bmem_rvalid = 0;

        // 2: simultaneous reads, D first then I; returns in issue order
        do_reset();
        i_read = 1; d_read = 1; bmem_ready = 1;
        settle();
        chk("t2_first_dready", 64'(d_ready), 64'd1);
        chk("t2_first_iready", 64'(i_ready), 64'd0);
        chk("t2_first_addr", 64'(bmem_addr), 64'(c_DA));
        tick();
        d_read = 0;
        settle();
        chk("t2_second_iready", 64'(i_ready), 64'd1);
        chk("t2_second_addr", 64'(bmem_addr), 64'(c_IA));
        tick();
        i_read = 0;
        for (int b = 0; b < 8; b++) begin
            bmem_rvalid = 1;
            settle();
            chk($sformatf("t2_b%0d_drv", b), 64'(d_rvalid), 64'(b < 4));
            chk($sformatf("t2_b%0d_irv", b), 64'(i_rvalid), 64'(b >= 4));
            tick();
            bmem_rvalid = 0;
            if (b == 1 || b == 5) tick();
        end

        // 3: D write burst locks out a concurrent I read
        do_reset();
        d_write = 1; i_read = 1; bmem_ready = 1;
        settle();
        chk("t3_b0_write", 64'(bmem_write), 64'd1);
        chk("t3_b0_dready", 64'(d_ready), 64'd1);
        chk("t3_b0_iready", 64'(i_ready), 64'd0);
        chk("t3_b0_addr", 64'(bmem_addr), 64'(c_DA));
        tick();
        d_addr = 32'hDEAD_0000;
        for (int b = 1; b < 4; b++) begin
            d_wdata = 64'hD0 + 64'(b);
            settle();
            chk($sformatf("t3_b%0d_write", b), 64'(bmem_write), 64'd1);
            chk($sformatf("t3_b%0d_read", b), 64'(bmem_read), 64'd0);
            chk($sformatf("t3_b%0d_iready", b), 64'(i_ready), 64'd0);
            chk($sformatf("t3_b%0d_addr", b), 64'(bmem_addr), 64'(c_DA));
            chk($sformatf("t3_b%0d_wdata", b), bmem_wdata, 64'hD0 + 64'(b));
            tick();
        end
        d_write = 0; d_addr = c_DA;
        settle();
        chk("t3_after_iready", 64'(i_ready), 64'd1);
        chk("t3_after_read", 64'(bmem_read), 64'd1);
        chk("t3_after_addr", 64'(bmem_addr), 64'(c_IA));

        // 4: FIFO full blocks reads; a D write still wins; no bypass on pop
        do_reset();
        i_read = 1; bmem_ready = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("t4_issue%0d", k), 64'(i_ready), 64'd1);
            tick();
        end
        settle();
        chk("t4_full_iready", 64'(i_ready), 64'd0);
        chk("t4_full_read", 64'(bmem_read), 64'd0);
        tick();
        d_write = 1; bmem_ready = 0;
        settle();
        chk("t4_dwrite_wins", 64'(bmem_write), 64'd1);
        chk("t4_dwrite_noread", 64'(bmem_read), 64'd0);
        chk("t4_dwrite_addr", 64'(bmem_addr), 64'(c_DA));
        tick();
        d_write = 0; bmem_ready = 1;
        for (int b = 0; b < 4; b++) begin
            bmem_rvalid = 1;
            settle();
            chk($sformatf("t4_ret%0d_iready", b), 64'(i_ready), 64'd0);
            chk($sformatf("t4_ret%0d_irv", b), 64'(i_rvalid), 64'd1);
            tick();
        end
        bmem_rvalid = 0;
        settle();
        chk("t4_freed_iready", 64'(i_ready), 64'd1);
        chk("t4_freed_read", 64'(bmem_read), 64'd1);
        tick();
        i_read = 0;

        // 5: bmem_ready toggling during a D write burst
        do_reset();
        d_write = 1; d_addr = 32'h3000; i_read = 1; bmem_ready = 1;
        settle();
        chk("t5_b0_dready", 64'(d_ready), 64'd1);
        tick();
        acc = 1;
        for (int k = 0; k < 6; k++) begin
            bmem_ready = k[0];
            settle();
            chk($sformatf("t5_c%0d_addr", k), 64'(bmem_addr), 64'h3000);
            chk($sformatf("t5_c%0d_dready", k), 64'(d_ready), 64'(k[0]));
            chk($sformatf("t5_c%0d_iready", k), 64'(i_ready), 64'd0);
            if (k[0]) acc++;
            tick();
        end
        chk("t5_beats", 64'(acc), 64'd4);
        d_write = 0; d_addr = c_DA; bmem_ready = 1;
        settle();
        chk("t5_idle_iready", 64'(i_ready), 64'd1);
        chk("t5_idle_read", 64'(bmem_read), 64'd1);

        // 6: reset mid-burst clears FSM and outstanding reads
        do_reset();
        d_read = 1; bmem_ready = 1;
        tick();
        d_read = 0; d_write = 1;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        clear_inputs();
        settle();
        chk_all_zero("t6_post_rst");
        tick();
        i_read = 1; bmem_ready = 1;
        settle();
        chk("t6_iready", 64'(i_ready), 64'd1);
        chk("t6_read", 64'(bmem_read), 64'd1);
        chk("t6_addr", 64'(bmem_addr), 64'(c_IA));
        tick();
        i_read = 0; bmem_rvalid = 1;
        settle();
        chk("t6_ret_irv", 64'(i_rvalid), 64'd1);
        chk("t6_ret_drv", 64'(d_rvalid), 64'd0);
        tick();
        bmem_rvalid = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
